// File: rtl/alu_operand_ctrl_pkg.sv
// Shared constants and types for the EX-stage ALU operand controller.
// Forwarding select encodings, widths and the control bundle a bubble loads.
package alu_operand_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
        logic alusrc;
    } ex_ctrl_t;

    // Control bits forced into EX when no real instruction advances.
    localparam ex_ctrl_t BUBBLE_CTRL = '{valid: 1'b0, regwrite: 1'b0, memread: 1'b0, alusrc: 1'b0};

endpackage

// File: rtl/alu_operand_ctrl_fwd_select.sv
// Forwarding comparator for one ALU operand: picks EX/MEM, MEM/WB or the
// register file. EX/MEM has priority and register $0 never forwards.
module fwd_select
    import alu_operand_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             uses,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             mem_we,
    input  logic [REG_W-1:0] wb_dst,
    input  logic             wb_we,
    output logic [1:0]       sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = uses && mem_we && (mem_dst != '0) && (mem_dst == src);
    assign wb_hit  = uses && wb_we  && (wb_dst  != '0) && (wb_dst  == src);

    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/alu_operand_ctrl.sv
// EX-stage operand sequencing: tracks destinations through EX/MEM/WB and
// drives forwarding selects, the busB immediate select and the load-use stall.
module alu_operand_ctrl
    import alu_operand_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_alusrc,
    input  logic             ext_hold,
    input  logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             alusrc_sel,
    output logic             stall,
    output logic             ex_valid,
    output logic [CNT_W-1:0] stall_count
);

    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic             ex_uses_rs;
    logic             ex_uses_rt;
    logic [REG_W-1:0] ex_dst;
    ex_ctrl_t         ex_ctrl;
    logic [REG_W-1:0] mem_dst;
    logic             mem_regwrite;
    logic [REG_W-1:0] wb_dst;
    logic             wb_regwrite;

    ex_ctrl_t         ex_ctrl_next;
    logic             rs_hazard;
    logic             rt_hazard;

    // Load-use: a load in EX whose destination the ID instruction reads.
    assign rs_hazard = id_uses_rs && (id_rs == ex_dst);
    assign rt_hazard = id_uses_rt && (id_rt == ex_dst);
    assign stall     = ex_ctrl.memread && ex_ctrl.valid && (ex_dst != '0) &&
                       id_valid && (rs_hazard || rt_hazard);

    assign ex_valid   = ex_ctrl.valid;
    assign alusrc_sel = ex_ctrl.alusrc && ex_ctrl.valid;

    always_comb begin
        ex_ctrl_next = BUBBLE_CTRL;
        if (id_valid && !stall && !flush) begin
            ex_ctrl_next.valid    = 1'b1;
            ex_ctrl_next.regwrite = id_regwrite;
            ex_ctrl_next.memread  = id_memread;
            ex_ctrl_next.alusrc   = id_alusrc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_uses_rs   <= 1'b0;
            ex_uses_rt   <= 1'b0;
            ex_dst       <= '0;
            ex_ctrl      <= BUBBLE_CTRL;
            mem_dst      <= '0;
            mem_regwrite <= 1'b0;
            wb_dst       <= '0;
            wb_regwrite  <= 1'b0;
        end else if (!ext_hold) begin
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_uses_rs   <= id_uses_rs;
            ex_uses_rt   <= id_uses_rt;
            ex_dst       <= id_dst;
            ex_ctrl      <= ex_ctrl_next;
            mem_dst      <= ex_dst;
            mem_regwrite <= ex_ctrl.regwrite;
            wb_dst       <= mem_dst;
            wb_regwrite  <= mem_regwrite;
        end
    end

    // A stall held across ext_hold is counted once, on the releasing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && !ext_hold && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    fwd_select u_fwd_a (
        .src     (ex_rs),
        .uses    (ex_uses_rs),
        .mem_dst (mem_dst),
        .mem_we  (mem_regwrite),
        .wb_dst  (wb_dst),
        .wb_we   (wb_regwrite),
        .sel     (fwd_a_sel)
    );

    fwd_select u_fwd_b (
        .src     (ex_rt),
        .uses    (ex_uses_rt),
        .mem_dst (mem_dst),
        .mem_we  (mem_regwrite),
        .wb_dst  (wb_dst),
        .wb_we   (wb_regwrite),
        .sel     (fwd_b_sel)
    );

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Directed bench for alu_operand_ctrl: a per-cycle vector table for the
// instruction sequences, then hand-written ext_hold and mid-stall reset cases.
module tb_alu_operand_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  id_dst;
    logic        id_regwrite;
    logic        id_memread;
    logic        id_alusrc;
    logic        ext_hold;
    logic        flush;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        alusrc_sel;
    logic        stall;
    logic        ex_valid;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    alu_operand_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_dst      (id_dst),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .id_alusrc   (id_alusrc),
        .ext_hold    (ext_hold),
        .flush       (flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .alusrc_sel  (alusrc_sel),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .stall_count (stall_count)
    );

    // ---------------- instruction encoding ----------------
    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
        logic       as;
    } instr_t;

    typedef struct {
        string      name;
        instr_t     id;
        logic       flush;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       eas;
        logic       est;
        logic       eexv;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic instr_t ins(input logic v, input int rs, input int rt,
                                   input logic urs, input logic urt, input int dst,
                                   input logic rw, input logic mr, input logic as);
        instr_t r;
        r.v = v; r.rs = 5'(rs); r.rt = 5'(rt); r.urs = urs; r.urt = urt;
        r.dst = 5'(dst); r.rw = rw; r.mr = mr; r.as = as;
        return r;
    endfunction

    task automatic add_vec(input string name, input instr_t id, input logic fl,
                           input logic [1:0] ea, input logic [1:0] eb, input logic eas,
                           input logic est, input logic eexv, input int ecnt);
        vec_t v;
        v.name = name; v.id = id; v.flush = fl; v.ea = ea; v.eb = eb;
        v.eas = eas; v.est = est; v.eexv = eexv; v.ecnt = 16'(ecnt);
        vecs.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_id(input instr_t i);
        id_valid    = i.v;
        id_rs       = i.rs;
        id_rt       = i.rt;
        id_uses_rs  = i.urs;
        id_uses_rt  = i.urt;
        id_dst      = i.dst;
        id_regwrite = i.rw;
        id_memread  = i.mr;
        id_alusrc   = i.as;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [1:0] ea, input logic [1:0] eb,
                           input logic eas, input logic est, input logic eexv,
                           input logic [15:0] ecnt);
        chk({name, ".fwd_a"}, 32'(fwd_a_sel), 32'(ea));
        chk({name, ".fwd_b"}, 32'(fwd_b_sel), 32'(eb));
        chk({name, ".alusrc"}, 32'(alusrc_sel), 32'(eas));
        chk({name, ".stall"}, 32'(stall), 32'(est));
        chk({name, ".ex_valid"}, 32'(ex_valid), 32'(eexv));
        chk({name, ".stall_count"}, 32'(stall_count), 32'(ecnt));
    endtask

    instr_t nop, a_r3, a_r4_r3, sub_r6, addi_r3, add_r8, lw_r5, use_r5, add_w0, add_r0r0, lw_r0, use_r0;

    initial begin
        nop      = ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
        a_r3     = ins(1, 1, 2, 1, 1, 3, 1, 0, 0); // add r3,r1,r2
        a_r4_r3  = ins(1, 3, 5, 1, 1, 4, 1, 0, 0); // add r4,r3,r5
        sub_r6   = ins(1, 7, 3, 1, 1, 6, 1, 0, 0); // sub r6,r7,r3
        addi_r3  = ins(1, 3, 3, 1, 0, 3, 1, 0, 1); // addi r3,r3,imm
        add_r8   = ins(1, 3, 3, 1, 1, 8, 1, 0, 0); // add r8,r3,r3
        lw_r5    = ins(1, 1, 5, 1, 0, 5, 1, 1, 1); // lw r5,0(r1)
        use_r5   = ins(1, 5, 2, 1, 1, 6, 1, 0, 0); // add r6,r5,r2
        add_w0   = ins(1, 1, 2, 1, 1, 0, 1, 0, 0); // add r0,r1,r2
        add_r0r0 = ins(1, 0, 0, 1, 1, 4, 1, 0, 0); // add r4,r0,r0
        lw_r0    = ins(1, 1, 0, 1, 0, 0, 1, 1, 1); // lw r0,0(r1)
        use_r0   = ins(1, 0, 2, 1, 1, 6, 1, 0, 0); // add r6,r0,r2

        //        name        ID        fl  ea     eb     as st exv cnt
        add_vec("c0_add",    a_r3,     0, 2'b00, 2'b00, 0, 0, 0, 0);
        add_vec("c1_dep",    a_r4_r3,  0, 2'b00, 2'b00, 0, 0, 1, 0);
        add_vec("c2_exmem",  nop,      0, 2'b01, 2'b00, 0, 0, 1, 0);
        add_vec("c3_nop",    nop,      0, 2'b00, 2'b00, 0, 0, 0, 0);
        add_vec("c4_add",    a_r3,     0, 2'b00, 2'b00, 0, 0, 0, 0);
        add_vec("c5_nop",    nop,      0, 2'b00, 2'b00, 0, 0, 1, 0);
        add_vec("c6_sub",    sub_r6,   0, 2'b00, 2'b00, 0, 0, 0, 0);
        add_vec("c7_memwb",  a_r3,     0, 2'b00, 2'b10, 0, 0, 1, 0);
        add_vec("c8_addi",   addi_r3,  0, 2'b00, 2'b00, 0, 0, 1, 0);
        add_vec("c9_imm",    add_r8,   0, 2'b01, 2'b00, 1, 0, 1, 0);
        add_vec("c10_prio",  nop,      0, 2'b01, 2'b01, 0, 0, 1, 0);
        add_vec("c11_lw",    lw_r5,    0, 2'b00, 2'b00, 0, 0, 0, 0);
        add_vec("c12_luse",  use_r5,   0, 2'b00, 2'b00, 1, 1, 1, 0);
        add_vec("c13_bub",   use_r5,   0, 2'b01, 2'b00, 0, 0, 0, 1);
        add_vec("c14_wbfw",  nop,      0, 2'b10, 2'b00, 0, 0, 1, 1);
        add_vec("c15_w0",    add_w0,   0, 2'b00, 2'b00, 0, 0, 0, 1);
        add_vec("c16_r0r0",  add_r0r0, 0, 2'b00, 2'b00, 0, 0, 1, 1);
        add_vec("c17_lw0",   lw_r0,    0, 2'b00, 2'b00, 0, 0, 1, 1);
        add_vec("c18_use0",  use_r0,   0, 2'b00, 2'b00, 1, 0, 1, 1);
        add_vec("c19_nop",   nop,      0, 2'b00, 2'b00, 0, 0, 1, 1);
        add_vec("c20_lw",    lw_r5,    0, 2'b00, 2'b00, 0, 0, 0, 1);
        add_vec("c21_flush", use_r5,   1, 2'b00, 2'b00, 1, 1, 1, 1);
        add_vec("c22_after", nop,      0, 2'b01, 2'b00, 0, 0, 0, 2);

        // reset
        rst_n = 1'b0;
        ext_hold = 1'b0;
        flush = 1'b0;
        drive_id(nop);
        tick();
        tick();
        chk_all("reset", 2'b00, 2'b00, 0, 0, 0, 16'd0);
        rst_n = 1'b1;

        // table-driven cycles: drive ID, let it settle, compare, clock
        foreach (vecs[i]) begin
            drive_id(vecs[i].id);
            flush = vecs[i].flush;
            #2;
            chk_all(vecs[i].name, vecs[i].ea, vecs[i].eb, vecs[i].eas,
                    vecs[i].est, vecs[i].eexv, vecs[i].ecnt);
            tick();
        end
        flush = 1'b0;

        // load-use held by ext_hold for three cycles: stall counted once on release
        drive_id(lw_r5);
        tick();
        drive_id(use_r5);
        #2;
        chk_all("hold_pre", 2'b00, 2'b00, 1, 1, 1, 16'd2);
        ext_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk_all($sformatf("hold_%0d", k), 2'b00, 2'b00, 1, 1, 1, 16'd2);
        end
        ext_hold = 1'b0;
        tick();
        #1;
        chk_all("hold_rel", 2'b01, 2'b00, 0, 0, 0, 16'd3);
        drive_id(nop);
        tick();

        // reset pulse in the middle of a load-use stall
        drive_id(lw_r5);
        tick();
        drive_id(use_r5);
        #2;
        chk("rst_pre.stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all("rst_mid", 2'b00, 2'b00, 0, 0, 0, 16'd0);
        drive_id(nop);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        chk_all("rst_after", 2'b00, 2'b00, 0, 0, 0, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_ctrl.md
# alu_operand_ctrl

Sequencing controller for the EX-stage ALU operand muxes of the 5-stage pipelined MIPS core. It tracks destination-register state through EX, MEM and WB, and generates three things: forwarding selects for ALU operands A and B, the immediate/register select for the 32-bit 2:1 busB mux, and a load-use stall that inserts one bubble. It sits beside the ID/EX pipeline register and drives select lines only; it carries no 32-bit data.

## Interface
- REG_W, 5: register-specifier width
- CNT_W, 16: stall-counter width
- clk in 1: pipeline clock, all state on rising edge
- rst_n in 1: asynchronous, active-low reset
- id_valid in 1: ID holds a real instruction
- id_rs, id_rt in REG_W: source specifiers of the ID instruction
- id_uses_rs, id_uses_rt in 1: ID instruction actually reads rs / rt
- id_dst in REG_W: already-resolved destination (rd/rt/31)
- id_regwrite, id_memread, id_alusrc in 1: decoded controls
- ext_hold in 1: memory wait; freezes all internal state
- flush in 1: taken branch/jump; squash ID instruction
- fwd_a_sel, fwd_b_sel out 2: 00 register file, 01 EX/MEM result, 10 MEM/WB result
- alusrc_sel out 1: busB mux select; 0 = forwarded busB, 1 = sign-extended immediate
- stall out 1: hold PC and IF/ID; bubble into EX
- ex_valid out 1: EX stage holds a real instruction
- stall_count out CNT_W: saturating count of load-use stall cycles

## Operation
- State registers:
  - EX: rs, rt, uses_rs, uses_rt, dst, regwrite, memread, alusrc, valid
  - MEM: dst, regwrite
  - WB: dst, regwrite
- Each edge without ext_hold, state advances ID→EX→MEM→WB. EX loads a bubble (valid, regwrite, memread, alusrc all 0) when stall=1, flush=1 or id_valid=0.
- Forwarding for operand A, evaluated per cycle from EX vs MEM/WB state (B is identical, using ex_rt / ex_uses_rt):
  - 01 if mem_regwrite, mem_dst≠0, mem_dst==ex_rs and ex_uses_rs
  - else 10 if wb_regwrite, wb_dst≠0, wb_dst==ex_rs and ex_uses_rs
  - else 00
  - EX/MEM always wins over MEM/WB.
- alusrc_sel = ex_alusrc & ex_valid. The fwd_b_sel value is still produced when the immediate is selected, for store data.
- Load-use hazard: stall = ex_memread & ex_valid & ex_dst≠0 & id_valid & ((id_uses_rs & id_rs==ex_dst) | (id_uses_rt & id_rt==ex_dst)).
- Register $0 is never a forwarding or hazard source.
- flush with a pending stall: flush wins, bubble inserted. stall is still reported that cycle because fetch is redirected anyway.
- stall_count increments on each edge where stall=1 and ext_hold=0, saturating at all-ones.

## Timing
- Reset (async assert, sync-safe deassert): all state 0. Outputs fwd_a_sel=fwd_b_sel=00, alusrc_sel=0, stall=0, ex_valid=0, stall_count=0.
- fwd_*_sel, alusrc_sel and stall are combinational from current registers and ID inputs, settling within the same cycle.
- Forwarding latency: a producer in EX at cycle n gives a consumer in EX at n+1 select 01, or at n+2 select 10.
- Load-use costs exactly one stall cycle. The consumer then sees select 10 from the load in WB.
- ext_hold=1: no register updates, stall_count frozen. Outputs still reflect frozen state.
- ext_hold together with a hazard: stall stays asserted for the whole hold and is counted once, on release.
- rst_n asserted mid-stall: stall drops immediately, and the pipeline state is cleared.

## Structure
- Shared package/header: FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, REG_W, and the bubble-control constant.
- Sub-module fwd_select: a combinational comparator taking (src, uses, mem_dst, mem_we, wb_dst, wb_we) and returning a 2-bit select. It is instanced twice, once per operand.
- The top level holds the stage registers, hazard logic and counter; target about 180 lines.

## Test plan
- add r3,r1,r2 then add r4,r3,r5 → cycle 2 fwd_a_sel=01, fwd_b_sel=00.
- add r3 ; nop ; sub r6,r7,r3 → sub in EX: fwd_b_sel=10.
- add r3 then addi r3 then add r8,r3,r3 → fwd_a_sel=fwd_b_sel=01 (EX/MEM priority). Also addi gives alusrc_sel=1.
- lw r5,0(r1) then add r6,r5,r2 → stall=1 for one cycle, ex_valid=0 next cycle, then fwd_a_sel=10, stall_count=1.
- add r0,r1,r2 then add r4,r0,r0 → selects stay 00. Likewise lw r0 followed by a consumer of r0 → stall=0.
- Load-use with ext_hold=1 for 3 cycles → state frozen, stall_count=1 after release. rst_n pulse mid-stall → all outputs 0 immediately.
